pwr_domain_resp: RTL and testbench

Power-domain responder on the far side of the power controller's PSO control bus. It consumes the switch enables, isolation, clock-gate and save/restore edges, and models the switchable domain. It models power-switch ramp-up, always-on retention capture and replay, and output isolation clamping. Every protocol-ordering violation is flagged, so the controller can be verified closed-loop and the domain can be dropped into SoC simulation.

---
 rtl/pwr_domain_resp.sv | 188 ++++++++++++++++++
 tb/tb_pwr_domain_resp.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_domain_resp.sv
// Switchable power-domain responder: power-switch ramp sequencing, always-on
// retention save/restore, output isolation clamp and sticky protocol-error capture.
module pwr_domain_resp #(
    parameter int unsigned      RAMP1_CYC = 4,
    parameter int unsigned      RAMP2_CYC = 8,
    parameter int unsigned      REG_W     = 32,
    parameter logic [REG_W-1:0] ISO_VAL   = {REG_W{1'b0}}
) (
    input  logic             pclk,
    input  logic             prst,
    input  logic             pwr1_on,
    input  logic             pwr2_on,
    input  logic             isolate_module,
    input  logic             gate_clk_module,
    input  logic             save_edge,
    input  logic             restore_edge,
    input  logic [REG_W-1:0] live_data,
    input  logic [REG_W-1:0] dom_out_raw,
    output logic [REG_W-1:0] dom_out,
    output logic             pwr_good,
    output logic [1:0]       domain_state,
    output logic [REG_W-1:0] ret_data,
    output logic             save_done,
    output logic             restore_valid,
    output logic [REG_W-1:0] restored_data,
    output logic             err_seq,
    output logic [2:0]       err_code
);

    localparam logic [1:0] ST_ON    = 2'd0;
    localparam logic [1:0] ST_OFF   = 2'd1;
    localparam logic [1:0] ST_RAMP1 = 2'd2;
    localparam logic [1:0] ST_RAMP2 = 2'd3;

    localparam logic [2:0] ERR_NONE            = 3'd0;
    localparam logic [2:0] ERR_PWR_ORDER       = 3'd1;
    localparam logic [2:0] ERR_ISO_MISSING     = 3'd2;
    localparam logic [2:0] ERR_SAVE_NO_ISO     = 3'd3;
    localparam logic [2:0] ERR_RESTORE_EARLY   = 3'd4;
    localparam logic [2:0] ERR_RESTORE_NO_DATA = 3'd5;
    localparam logic [2:0] ERR_CLK_UNGATED     = 3'd6;

    // Counter loads are one less than the ramp length: the zero cycle is the last ramp cycle.
    localparam logic [4:0] RAMP1_LOAD = 5'(RAMP1_CYC - 1);
    localparam logic [4:0] RAMP2_LOAD = 5'(RAMP2_CYC - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [4:0]       r_cnt;
    logic [4:0]       w_cnt_next;
    logic [REG_W-1:0] r_ret_data;
    logic             r_ret_valid;
    logic [REG_W-1:0] r_restored_data;
    logic             r_save_done;
    logic             r_restore_valid;
    logic             r_err_seq;
    logic [2:0]       r_err_code;

    logic             w_on;
    logic             w_off;
    logic             w_save_ok;
    logic             w_restore_ok;
    logic [6:1]       w_err_vec;
    logic             w_err_any;
    logic [2:0]       w_err_code;

    assign w_on  = (r_state == ST_ON);
    assign w_off = (r_state == ST_OFF);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_ON: begin
                if (!(pwr1_on && pwr2_on)) begin
                    w_state_next = ST_OFF;
                end
            end
            ST_OFF: begin
                if (pwr1_on) begin
                    w_state_next = ST_RAMP1;
                    w_cnt_next   = RAMP1_LOAD;
                end
            end
            ST_RAMP1: begin
                if (!pwr1_on) begin
                    w_state_next = ST_OFF;
                end else if (r_cnt != 5'd0) begin
                    w_cnt_next = r_cnt - 5'd1;
                end else if (pwr2_on) begin
                    w_state_next = ST_RAMP2;
                    w_cnt_next   = RAMP2_LOAD;
                end
            end
            ST_RAMP2: begin
                if (!(pwr1_on && pwr2_on)) begin
                    w_state_next = ST_OFF;
                end else if (r_cnt == 5'd0) begin
                    w_state_next = ST_ON;
                end else begin
                    w_cnt_next = r_cnt - 5'd1;
                end
            end
            default: begin
                w_state_next = ST_ON;
            end
        endcase
    end

    assign w_save_ok    = save_edge & w_on & isolate_module & gate_clk_module;
    assign w_restore_ok = restore_edge & w_on & r_ret_valid;

    // One bit per error code; all are evaluated against the pre-edge state.
    assign w_err_vec[1] = (w_on & (pwr1_on ^ pwr2_on)) | (w_off & pwr2_on & ~pwr1_on);
    assign w_err_vec[2] = ~w_on & ~isolate_module;
    assign w_err_vec[3] = save_edge & ~w_save_ok;
    assign w_err_vec[4] = restore_edge & ~w_on;
    assign w_err_vec[5] = restore_edge & w_on & ~r_ret_valid;
    assign w_err_vec[6] = ~w_on & ~gate_clk_module;
    assign w_err_any    = |w_err_vec;

    always_comb begin
        w_err_code = ERR_NONE;
        if (w_err_vec[1]) begin
            w_err_code = ERR_PWR_ORDER;
        end else if (w_err_vec[2]) begin
            w_err_code = ERR_ISO_MISSING;
        end else if (w_err_vec[3]) begin
            w_err_code = ERR_SAVE_NO_ISO;
        end else if (w_err_vec[4]) begin
            w_err_code = ERR_RESTORE_EARLY;
        end else if (w_err_vec[5]) begin
            w_err_code = ERR_RESTORE_NO_DATA;
        end else if (w_err_vec[6]) begin
            w_err_code = ERR_CLK_UNGATED;
        end
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            r_state         <= ST_ON;
            r_cnt           <= 5'd0;
            r_ret_data      <= '0;
            r_ret_valid     <= 1'b0;
            r_restored_data <= '0;
            r_save_done     <= 1'b0;
            r_restore_valid <= 1'b0;
            r_err_seq       <= 1'b0;
            r_err_code      <= ERR_NONE;
        end else begin
            r_state         <= w_state_next;
            r_cnt           <= w_cnt_next;
            r_save_done     <= w_save_ok;
            r_restore_valid <= w_restore_ok;
            // A same-cycle save wins over the restore's invalidation.
            if (w_save_ok) begin
                r_ret_data  <= live_data;
                r_ret_valid <= 1'b1;
            end else if (w_restore_ok) begin
                r_ret_valid <= 1'b0;
            end
            if (w_restore_ok) begin
                r_restored_data <= r_ret_data;
            end
            if (w_err_any && !r_err_seq) begin
                r_err_seq  <= 1'b1;
                r_err_code <= w_err_code;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < REG_W; gi++) begin : g_iso
            assign dom_out[gi] = isolate_module ? ISO_VAL[gi] : dom_out_raw[gi];
        end
    endgenerate

    assign pwr_good      = w_on;
    assign domain_state  = r_state;
    assign ret_data      = r_ret_data;
    assign save_done     = r_save_done;
    assign restore_valid = r_restore_valid;
    assign restored_data = r_restored_data;
    assign err_seq       = r_err_seq;
    assign err_code      = r_err_code;

endmodule

// File: tb/tb_pwr_domain_resp.sv
// Self-checking bench for pwr_domain_resp: vector table, directed PSO sequences,
// then randomized stimulus against a cycle-counting reference model.
module tb_pwr_domain_resp;

    localparam int R1 = 4;
    localparam int R2 = 8;

    logic        pclk = 1'b0;
    logic        prst;
    logic        pwr1_on, pwr2_on, isolate_module, gate_clk_module;
    logic        save_edge, restore_edge;
    logic [31:0] live_data, dom_out_raw;
    logic [31:0] dom_out, ret_data, restored_data;
    logic        pwr_good, save_done, restore_valid, err_seq;
    logic [1:0]  domain_state;
    logic [2:0]  err_code;

    int n_pass  = 0;
    int n_total = 0;

    pwr_domain_resp #(
        .RAMP1_CYC (R1),
        .RAMP2_CYC (R2),
        .REG_W     (32),
        .ISO_VAL   (32'h0)
    ) dut (
        .pclk            (pclk),
        .prst            (prst),
        .pwr1_on         (pwr1_on),
        .pwr2_on         (pwr2_on),
        .isolate_module  (isolate_module),
        .gate_clk_module (gate_clk_module),
        .save_edge       (save_edge),
        .restore_edge    (restore_edge),
        .live_data       (live_data),
        .dom_out_raw     (dom_out_raw),
        .dom_out         (dom_out),
        .pwr_good        (pwr_good),
        .domain_state    (domain_state),
        .ret_data        (ret_data),
        .save_done       (save_done),
        .restore_valid   (restore_valid),
        .restored_data   (restored_data),
        .err_seq         (err_seq),
        .err_code        (err_code)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        p1, p2, iso, gate, sv, rs;
        logic [31:0] live, raw;
        logic [1:0]  e_state;
        logic        e_pg;
        logic [31:0] e_dom;
        logic        e_sd, e_rv;
        logic [31:0] e_ret, e_rst;
        logic        e_es;
        logic [2:0]  e_ec;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_idle();
        prst = 1'b0; pwr1_on = 1'b1; pwr2_on = 1'b1;
        isolate_module = 1'b1; gate_clk_module = 1'b1;
        save_edge = 1'b0; restore_edge = 1'b0;
        live_data = '0; dom_out_raw = '0;
    endtask

    task automatic do_reset(input bit check);
        prst = 1'b1;
        pwr1_on = 1'($urandom); pwr2_on = 1'($urandom);
        isolate_module = 1'($urandom); gate_clk_module = 1'($urandom);
        save_edge = 1'($urandom); restore_edge = 1'($urandom);
        live_data = $urandom; dom_out_raw = $urandom;
        tick(); tick();
        if (check) begin
            chk("rst_state", 32'(domain_state), 32'd0);
            chk("rst_pg", 32'(pwr_good), 32'd1);
            chk("rst_ret", ret_data, 32'h0);
            chk("rst_restored", restored_data, 32'h0);
            chk("rst_sd", 32'(save_done), 32'd0);
            chk("rst_rv", 32'(restore_valid), 32'd0);
            chk("rst_es", 32'(err_seq), 32'd0);
            chk("rst_ec", 32'(err_code), 32'd0);
        end
        set_idle();
    endtask

    // Reference model: tracks power phase plus number of edges spent in the current ramp.
    int          m_state, m_age, m_ec;
    logic [31:0] m_ret, m_rst;
    bit          m_ret_valid, m_sd, m_rvp, m_es;

    task automatic model_step();
        int  best;
        bit  powered;
        bit  sv_ok, rs_ok;
        if (prst) begin
            m_state = 0; m_age = 0; m_ec = 0; m_ret = 0; m_rst = 0;
            m_ret_valid = 0; m_sd = 0; m_rvp = 0; m_es = 0;
            return;
        end
        powered = (m_state == 0);
        best = 7;
        if (powered && (pwr1_on != pwr2_on)) best = (best < 1) ? best : 1;
        if (m_state == 1 && pwr2_on && !pwr1_on) best = (best < 1) ? best : 1;
        if (!powered && !isolate_module) best = (best < 2) ? best : 2;
        sv_ok = save_edge && powered && isolate_module && gate_clk_module;
        rs_ok = restore_edge && powered && m_ret_valid;
        if (save_edge && !sv_ok) best = (best < 3) ? best : 3;
        if (restore_edge && !powered) best = (best < 4) ? best : 4;
        if (restore_edge && powered && !m_ret_valid) best = (best < 5) ? best : 5;
        if (!powered && !gate_clk_module) best = (best < 6) ? best : 6;
        if (best < 7 && !m_es) begin m_es = 1; m_ec = best; end
        m_rvp = rs_ok;
        m_sd  = sv_ok;
        if (rs_ok) begin m_rst = m_ret; m_ret_valid = 0; end
        if (sv_ok) begin m_ret = live_data; m_ret_valid = 1; end
        case (m_state)
            0: if (!(pwr1_on && pwr2_on)) m_state = 1;
            1: if (pwr1_on) begin m_state = 2; m_age = 0; end
            2: begin
                if (!pwr1_on) m_state = 1;
                else if (m_age + 1 >= R1 && pwr2_on) begin m_state = 3; m_age = 0; end
                else m_age++;
            end
            default: begin
                if (!(pwr1_on && pwr2_on)) m_state = 1;
                else if (m_age + 1 >= R2) m_state = 0;
                else m_age++;
            end
        endcase
    endtask

    task automatic model_compare();
        chk("rnd_state", 32'(domain_state), 32'(m_state));
        chk("rnd_pg", 32'(pwr_good), 32'(m_state == 0));
        chk("rnd_dom", dom_out, isolate_module ? 32'h0 : dom_out_raw);
        chk("rnd_sd", 32'(save_done), 32'(m_sd));
        chk("rnd_rv", 32'(restore_valid), 32'(m_rvp));
        chk("rnd_ret", ret_data, m_ret);
        chk("rnd_restored", restored_data, m_rst);
        chk("rnd_es", 32'(err_seq), 32'(m_es));
        chk("rnd_ec", 32'(err_code), 32'(m_ec));
    endtask

    initial begin
        set_idle();
        prst = 1'b1;

        // Vector table applied one edge per row, starting from reset with power on.
        vecs[0] = '{1,1,0,0,0,0, 32'h0,        32'hDEADBEEF, 2'd0,1,32'hDEADBEEF,0,0,32'h0,       32'h0,       0,3'd0};
        vecs[1] = '{1,1,1,1,0,0, 32'h0,        32'hDEADBEEF, 2'd0,1,32'h0,       0,0,32'h0,       32'h0,       0,3'd0};
        vecs[2] = '{1,1,1,1,1,0, 32'h11112222, 32'hCAFEF00D, 2'd0,1,32'h0,       1,0,32'h11112222,32'h0,       0,3'd0};
        vecs[3] = '{1,1,1,1,0,1, 32'h0,        32'hCAFEF00D, 2'd0,1,32'h0,       0,1,32'h11112222,32'h11112222,0,3'd0};
        vecs[4] = '{1,1,0,1,0,1, 32'h0,        32'h0000FFFF, 2'd0,1,32'h0000FFFF,0,0,32'h11112222,32'h11112222,1,3'd5};
        vecs[5] = '{0,0,1,1,0,0, 32'h0,        32'h0000FFFF, 2'd1,0,32'h0,       0,0,32'h11112222,32'h11112222,1,3'd5};

        do_reset(1'b1);
        for (int i = 0; i < 6; i++) begin
            pwr1_on = vecs[i].p1; pwr2_on = vecs[i].p2;
            isolate_module = vecs[i].iso; gate_clk_module = vecs[i].gate;
            save_edge = vecs[i].sv; restore_edge = vecs[i].rs;
            live_data = vecs[i].live; dom_out_raw = vecs[i].raw;
            tick();
            chk($sformatf("vec%0d_state", i), 32'(domain_state), 32'(vecs[i].e_state));
            chk($sformatf("vec%0d_pg", i), 32'(pwr_good), 32'(vecs[i].e_pg));
            chk($sformatf("vec%0d_dom", i), dom_out, vecs[i].e_dom);
            chk($sformatf("vec%0d_sd", i), 32'(save_done), 32'(vecs[i].e_sd));
            chk($sformatf("vec%0d_rv", i), 32'(restore_valid), 32'(vecs[i].e_rv));
            chk($sformatf("vec%0d_ret", i), ret_data, vecs[i].e_ret);
            chk($sformatf("vec%0d_restored", i), restored_data, vecs[i].e_rst);
            chk($sformatf("vec%0d_es", i), 32'(err_seq), 32'(vecs[i].e_es));
            chk($sformatf("vec%0d_ec", i), 32'(err_code), 32'(vecs[i].e_ec));
        end

        // Full power-down / power-up cycle with retention.
        do_reset(1'b0);
        live_data = 32'hA5A5_0001; save_edge = 1'b1;
        tick();
        save_edge = 1'b0;
        chk("pso_ret", ret_data, 32'hA5A5_0001);
        chk("pso_sd", 32'(save_done), 32'd1);
        tick();
        chk("pso_sd_clr", 32'(save_done), 32'd0);
        pwr1_on = 1'b0; pwr2_on = 1'b0;
        tick();
        chk("pso_pg_off", 32'(pwr_good), 32'd0);
        chk("pso_state_off", 32'(domain_state), 32'd1);
        tick(); tick();
        pwr1_on = 1'b1;
        tick();
        chk("pso_state_r1", 32'(domain_state), 32'd2);
        pwr2_on = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("pso_pg_e0p%0d", k), 32'(pwr_good), 32'(k == 12));
        end
        for (int k = 13; k <= 27; k++) tick();
        restore_edge = 1'b1;
        tick();
        restore_edge = 1'b0;
        chk("pso_rv", 32'(restore_valid), 32'd1);
        chk("pso_restored", restored_data, 32'hA5A5_0001);
        tick();
        chk("pso_rv_single", 32'(restore_valid), 32'd0);
        chk("pso_es", 32'(err_seq), 32'd0);

        // Drop one switch while on.
        do_reset(1'b0);
        pwr1_on = 1'b0;
        tick();
        chk("order_state", 32'(domain_state), 32'd1);
        chk("order_es", 32'(err_seq), 32'd1);
        chk("order_ec", 32'(err_code), 32'd1);

        // Restore attempted during ramp.
        do_reset(1'b0);
        live_data = 32'h0BAD_CAFE; save_edge = 1'b1;
        tick();
        save_edge = 1'b0;
        pwr1_on = 1'b0; pwr2_on = 1'b0;
        tick();
        pwr1_on = 1'b1;
        tick();
        pwr2_on = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        restore_edge = 1'b1;
        tick();
        restore_edge = 1'b0;
        chk("early_ec", 32'(err_code), 32'd4);
        chk("early_rv", 32'(restore_valid), 32'd0);
        chk("early_ret", ret_data, 32'h0BAD_CAFE);
        tick();
        chk("early_rv2", 32'(restore_valid), 32'd0);

        // Isolation removed while off.
        do_reset(1'b0);
        pwr1_on = 1'b0; pwr2_on = 1'b0;
        tick();
        isolate_module = 1'b0; dom_out_raw = 32'h1234_5678;
        #1;
        chk("iso_pass", dom_out, 32'h1234_5678);
        tick();
        chk("iso_ec", 32'(err_code), 32'd2);
        isolate_module = 1'b1;
        #1;
        chk("iso_clamp", dom_out, 32'h0);

        // Simultaneous errors, then reset mid-ramp.
        do_reset(1'b0);
        pwr1_on = 1'b0; pwr2_on = 1'b0;
        tick();
        isolate_module = 1'b0; gate_clk_module = 1'b0;
        save_edge = 1'b1; live_data = 32'hFFFF_0000;
        tick();
        save_edge = 1'b0; isolate_module = 1'b1; gate_clk_module = 1'b1;
        chk("sim_ec", 32'(err_code), 32'd2);
        chk("sim_ret", ret_data, 32'h0);
        chk("sim_sd", 32'(save_done), 32'd0);
        pwr1_on = 1'b1; pwr2_on = 1'b1;
        for (int k = 0; k <= 4; k++) tick();
        chk("sim_state_r2", 32'(domain_state), 32'd3);
        prst = 1'b1;
        tick();
        chk("sim_rst_state", 32'(domain_state), 32'd0);
        chk("sim_rst_ret", ret_data, 32'h0);
        chk("sim_rst_es", 32'(err_seq), 32'd0);
        chk("sim_rst_ec", 32'(err_code), 32'd0);
        pwr1_on = 1'b0; pwr2_on = 1'b0;
        tick();
        chk("rst_lowen_on", 32'(domain_state), 32'd0);
        prst = 1'b0;
        tick();
        chk("rst_lowen_off", 32'(domain_state), 32'd1);

        // Randomized episodes against the reference model.
        for (int ep = 0; ep < 15; ep++) begin
            set_idle();
            for (int c = 0; c < 120; c++) begin
                prst = (c < 2) || ($urandom_range(255) == 0);
                if ($urandom_range(23) == 0) pwr1_on = ~pwr1_on;
                if ($urandom_range(23) == 0) pwr2_on = ~pwr2_on;
                isolate_module  = ($urandom_range(15) != 0);
                gate_clk_module = ($urandom_range(15) != 0);
                save_edge    = ($urandom_range(7) == 0);
                restore_edge = ($urandom_range(7) == 0);
                live_data    = $urandom;
                dom_out_raw  = $urandom;
                @(posedge pclk);
                model_step();
                #1;
                model_compare();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
